// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus access controller for a 5-stage MIPS pipeline.
// One load or store is issued per MEM instruction. The controller forms the
// byte enables and lane-replicated write data, holds the pipeline while the
// bus is busy, aborts after TIMEOUT wait cycles, and sign/zero-extends load data.
//
// Bus handshake: bus_req rises on the first ACCESS cycle and stays high, with
// bus_we/bus_addr/bus_be/bus_wdata frozen, until the memory answers with a
// one-cycle bus_ack (bus_rdata valid in that cycle) or the wait counter
// expires. bus_ack seen while bus_req is low has no effect.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic [5:0]  mem_opcode,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rdata_b,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_err,
  output logic        bus_err,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Last wait-counter value before the access is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;

  // Attributes of the access in flight, needed to shape the returned data.
  logic        acc_load;
  logic        acc_sext;
  logic [1:0]  acc_size;
  logic [1:0]  acc_lo;

  // Request decode from the MEM-stage inputs.
  logic [1:0]  req_size;
  logic        req_sext;
  logic        req_aligned;
  logic        req_legal;
  logic        req_illegal;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  // Load-return shaping.
  logic [7:0]  ret_byte;
  logic [15:0] ret_half;
  logic [31:0] ret_data;

  assign fsm_state = state;

  // Decode access size, alignment, byte enables and replicated store data.
  always_comb begin
    req_size = SZ_WORD;
    req_sext = 1'b0;
    case (mem_opcode)
      6'h20: begin req_size = SZ_BYTE; req_sext = 1'b1; end
      6'h24: req_size = SZ_BYTE;
      6'h28: req_size = SZ_BYTE;
      6'h21: begin req_size = SZ_HALF; req_sext = 1'b1; end
      6'h25: req_size = SZ_HALF;
      6'h29: req_size = SZ_HALF;
      default: req_size = SZ_WORD;   // LW, SW and any unlisted opcode
    endcase

    case (req_size)
      SZ_BYTE: begin
        req_aligned = 1'b1;
        req_be      = 4'b0001 << mem_alu_result[1:0];
        req_wdata   = {4{mem_rdata_b[7:0]}};
      end
      SZ_HALF: begin
        req_aligned = ~mem_alu_result[0];
        req_be      = 4'b0011 << {mem_alu_result[1], 1'b0};
        req_wdata   = {2{mem_rdata_b[15:0]}};
      end
      default: begin
        req_aligned = (mem_alu_result[1:0] == 2'b00);
        req_be      = 4'b1111;
        req_wdata   = mem_rdata_b;
      end
    endcase

    req_legal   = (mem_MemRead ^ mem_MemWrite) & req_aligned;
    req_illegal = (mem_MemRead | mem_MemWrite) & ~req_legal;
  end

  // Hold upstream while a legal request waits to launch or the bus is busy.
  always_comb begin
    stall = rst & (((state == IDLE) & req_legal) | (state == ACCESS));
  end

  // Select and extend the returned lane for the access in flight.
  always_comb begin
    case (acc_lo)
      2'd0:    ret_byte = bus_rdata[7:0];
      2'd1:    ret_byte = bus_rdata[15:8];
      2'd2:    ret_byte = bus_rdata[23:16];
      default: ret_byte = bus_rdata[31:24];
    endcase
    ret_half = acc_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (acc_size)
      SZ_BYTE: ret_data = {{24{acc_sext & ret_byte[7]}}, ret_byte};
      SZ_HALF: ret_data = {{16{acc_sext & ret_half[15]}}, ret_half};
      default: ret_data = bus_rdata;
    endcase
  end

  // Access FSM with registered bus outputs and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= 8'd0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_be     <= 4'd0;
      bus_wdata  <= 32'd0;
      load_data  <= 32'd0;
      load_valid <= 1'b0;
      addr_err   <= 1'b0;
      bus_err    <= 1'b0;
      acc_load   <= 1'b0;
      acc_sext   <= 1'b0;
      acc_size   <= SZ_WORD;
      acc_lo     <= 2'd0;
    end else begin
      load_valid <= 1'b0;
      addr_err   <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_legal) begin
            state     <= ACCESS;
            wait_cnt  <= 8'd0;
            bus_req   <= 1'b1;
            bus_we    <= mem_MemWrite;
            bus_addr  <= {mem_alu_result[31:2], 2'b00};
            bus_be    <= req_be;
            bus_wdata <= req_wdata;
            acc_load  <= mem_MemRead;
            acc_sext  <= req_sext;
            acc_size  <= req_size;
            acc_lo    <= mem_alu_result[1:0];
          end else if (req_illegal) begin
            addr_err <= 1'b1;
          end
        end
        ACCESS: begin
          if (bus_ack) begin
            state      <= DONE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            load_valid <= acc_load;
            if (acc_load) begin
              load_data <= ret_data;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // No answer from memory: abandon and return zero.
            state      <= DONE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_err    <= 1'b1;
            load_data  <= 32'd0;
            load_valid <= acc_load;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          // The instruction leaves MEM at this edge.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed MIPS loads/stores with a simple
// memory responder; expected bus requests, load results and error pulses are
// queued by the stimulus and consumed by an independent monitor.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [5:0]  mem_opcode;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_rdata_b;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        addr_err;
  logic        bus_err;
  logic [1:0]  fsm_state;

  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected bus request {we, addr, be, wdata}, load results, {addr_err, bus_err}.
  logic [68:0] exp_bus_q[$];
  logic [31:0] exp_load_q[$];
  logic [1:0]  exp_err_q[$];

  logic [68:0] cur_bus;
  logic        req_prev;

  mem_access_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_opcode(mem_opcode), .mem_alu_result(mem_alu_result),
    .mem_rdata_b(mem_rdata_b),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .addr_err(addr_err), .bus_err(bus_err), .fsm_state(fsm_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic flag_unexpected(input string name, input logic [68:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s act=%h exp=no_event", name, act);
  endtask

  // Monitor: compare every DUT event against the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      if (bus_req && !req_prev) begin
        if (exp_bus_q.size() == 0) flag_unexpected("bus_start", {bus_we, bus_addr, bus_be, bus_wdata});
        else begin
          cur_bus = exp_bus_q.pop_front();
          check("bus_start", {bus_we, bus_addr, bus_be, bus_wdata}, cur_bus);
        end
      end else if (bus_req) begin
        check("bus_hold", {bus_we, bus_addr, bus_be, bus_wdata}, cur_bus);
      end
      if (load_valid) begin
        if (exp_load_q.size() == 0) flag_unexpected("load_valid", 69'(load_data));
        else check("load_data", 69'(load_data), 69'(exp_load_q.pop_front()));
      end
      if (addr_err || bus_err) begin
        if (exp_err_q.size() == 0) flag_unexpected("err_pulse", 69'({addr_err, bus_err}));
        else check("err_pulse", 69'({addr_err, bus_err}), 69'(exp_err_q.pop_front()));
      end
    end
    req_prev = bus_req;
  end

  // Driver: present one MEM instruction, act as memory, count stall/req cycles.
  // ack_cyc = bus_req cycle number on which memory answers (0 = never).
  task automatic do_access(input string name, input logic rd, input logic wr,
                           input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] d, input logic [31:0] rdata,
                           input int ack_cyc, input int exp_stall, input int exp_req);
    int  n_stall;
    int  n_req;
    int  n_cyc;
    bit  done;
    @(posedge clk); #1;
    mem_MemRead    = rd;
    mem_MemWrite   = wr;
    mem_opcode     = op;
    mem_alu_result = addr;
    mem_rdata_b    = d;
    n_stall = 0; n_req = 0; n_cyc = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (bus_req) begin
        n_req++;
        bus_ack   = (n_req == ack_cyc);
        bus_rdata = rdata;
      end else begin
        bus_ack = 1'b0;
      end
      if (stall) n_stall++;
      else done = 1;
      n_cyc++;
      if (n_cyc > 40) begin
        flag_unexpected({name, "_watchdog"}, 69'(n_cyc));
        bus_ack = 1'b0;
        done = 1;
      end
    end
    check({name, "_stall_cycles"}, 69'(n_stall), 69'(exp_stall));
    check({name, "_req_cycles"}, 69'(n_req), 69'(exp_req));
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    mem_MemRead  = 1'b0;
    mem_MemWrite = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    // Reset with a request already on the inputs: nothing may stall or issue.
    rst = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0; req_prev = 1'b0;
    mem_MemRead = 1'b1; mem_MemWrite = 1'b0; mem_opcode = OP_LW;
    mem_alu_result = 32'h100; mem_rdata_b = 32'd0;
    cur_bus = '0;
    repeat (3) @(negedge clk);
    check("rst_stall", 69'(stall), 69'd0);
    check("rst_state", 69'(fsm_state), 69'd0);
    check("rst_bus", {bus_req, bus_we, bus_addr, bus_be, bus_wdata}, 70'd0);
    check("rst_flags", 69'({load_valid, addr_err, bus_err}), 69'd0);
    check("rst_load_data", 69'(load_data), 69'd0);
    mem_MemRead = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);

    // LW 0x100, ack on 3rd bus cycle.
    exp_bus_q.push_back({1'b0, 32'h100, 4'hF, 32'h0});
    exp_load_q.push_back(32'hDEADBEEF);
    do_access("lw", 1, 0, OP_LW, 32'h100, 0, 32'hDEADBEEF, 3, 4, 3);
    go_idle(1);

    // LB / LBU from the top lane.
    exp_bus_q.push_back({1'b0, 32'h100, 4'b1000, 32'h0});
    exp_load_q.push_back(32'hFFFFFF80);
    do_access("lb", 1, 0, OP_LB, 32'h103, 0, 32'h80123456, 1, 2, 1);
    exp_bus_q.push_back({1'b0, 32'h100, 4'b1000, 32'h0});
    exp_load_q.push_back(32'h00000080);
    do_access("lbu", 1, 0, OP_LBU, 32'h103, 0, 32'h80123456, 2, 3, 2);
    go_idle(1);

    // SH to the upper half: replicated data, no load result.
    exp_bus_q.push_back({1'b1, 32'h200, 4'b1100, 32'hABCDABCD});
    do_access("sh", 0, 1, OP_SH, 32'h202, 32'h0000ABCD, 0, 1, 2, 1);
    go_idle(1);

    // Misaligned word, both strobes, misaligned half, misaligned unlisted opcode.
    exp_err_q.push_back(2'b10);
    do_access("lw_mis", 1, 0, OP_LW, 32'h101, 0, 0, 1, 0, 0);
    exp_err_q.push_back(2'b10);
    do_access("rd_wr", 1, 1, OP_LW, 32'h100, 0, 0, 1, 0, 0);
    exp_err_q.push_back(2'b10);
    do_access("lh_mis", 1, 0, OP_LH, 32'h101, 0, 0, 1, 0, 0);
    exp_err_q.push_back(2'b10);
    do_access("unl_mis", 1, 0, 6'h3F, 32'h202, 0, 0, 1, 0, 0);
    go_idle(2);

    // Unlisted opcode treated as an aligned word.
    exp_bus_q.push_back({1'b0, 32'h204, 4'hF, 32'h0});
    exp_load_q.push_back(32'h13579BDF);
    do_access("unl_word", 1, 0, 6'h3F, 32'h204, 0, 32'h13579BDF, 1, 2, 1);
    go_idle(1);

    // Timeout: 16 bus cycles, bus_err, load returns zero.
    exp_bus_q.push_back({1'b0, 32'h300, 4'hF, 32'h0});
    exp_load_q.push_back(32'h0);
    exp_err_q.push_back(2'b01);
    do_access("lw_tmo", 1, 0, OP_LW, 32'h300, 0, 32'h55555555, 0, 17, 16);
    go_idle(1);
    check("tmo_state_idle", 69'(fsm_state), 69'd0);

    // SB replication, then SW followed back-to-back by LH/LHU.
    exp_bus_q.push_back({1'b1, 32'h100, 4'b0010, 32'hA5A5A5A5});
    do_access("sb", 0, 1, OP_SB, 32'h101, 32'h123456A5, 0, 1, 2, 1);
    exp_bus_q.push_back({1'b1, 32'h404, 4'hF, 32'hCAFEF00D});
    do_access("sw", 0, 1, OP_SW, 32'h404, 32'hCAFEF00D, 0, 2, 3, 2);
    exp_bus_q.push_back({1'b0, 32'h100, 4'b1100, 32'h0});
    exp_load_q.push_back(32'hFFFF8001);
    do_access("lh_b2b", 1, 0, OP_LH, 32'h102, 0, 32'h80017FFF, 2, 3, 2);
    exp_bus_q.push_back({1'b0, 32'h100, 4'b0011, 32'h0});
    exp_load_q.push_back(32'h00007FFF);
    do_access("lhu_b2b", 1, 0, OP_LHU, 32'h100, 0, 32'h80017FFF, 1, 2, 1);
    go_idle(2);

    // Stray ack while idle must be ignored.
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk); bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_ack_state", 69'(fsm_state), 69'd0);
    check("stray_ack_load", 69'(load_data), 69'h7FFF);

    // Reset in the 2nd ACCESS cycle, then a late ack.
    exp_bus_q.push_back({1'b0, 32'h500, 4'hF, 32'h0});
    @(posedge clk); #1;
    mem_MemRead = 1'b1; mem_MemWrite = 1'b0; mem_opcode = OP_LW;
    mem_alu_result = 32'h500; mem_rdata_b = 32'd0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_bus", {bus_req, bus_we, bus_addr, bus_be, bus_wdata}, 70'd0);
    check("midrst_load_data", 69'(load_data), 69'd0);
    check("midrst_stall", 69'(stall), 69'd0);
    check("midrst_state", 69'(fsm_state), 69'd0);
    @(posedge clk); #1;
    mem_MemRead = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk); bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("late_ack_state", 69'(fsm_state), 69'd0);
    check("late_ack_load", 69'(load_data), 69'd0);

    // Every queued expectation must have been consumed.
    repeat (2) @(negedge clk);
    check("bus_q_empty", 69'(exp_bus_q.size()), 69'd0);
    check("load_q_empty", 69'(exp_load_q.size()), 69'd0);
    check("err_q_empty", 69'(exp_err_q.size()), 69'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
